// File: rtl/seg7_pkg.sv
// Shared constants and types for the four-digit multiplexed seven-segment scanner.
package seg7_pkg;

  localparam int unsigned SEG_W = 7;
  localparam int unsigned AN_W  = 4;
  localparam int unsigned BCD_W = 4;

  typedef logic [SEG_W-1:0] seg_t;
  typedef logic [AN_W-1:0]  an_t;
  typedef logic [BCD_W-1:0] bcd_t;

  // Active-low cathode patterns, bit order {g,f,e,d,c,b,a}
  localparam seg_t SEG_0    = 7'b1000000;
  localparam seg_t SEG_1    = 7'b1111001;
  localparam seg_t SEG_2    = 7'b0100100;
  localparam seg_t SEG_3    = 7'b0110000;
  localparam seg_t SEG_4    = 7'b0011001;
  localparam seg_t SEG_5    = 7'b0010010;
  localparam seg_t SEG_6    = 7'b0000010;
  localparam seg_t SEG_7    = 7'b1111000;
  localparam seg_t SEG_8    = 7'b0000000;
  localparam seg_t SEG_9    = 7'b0010000;
  localparam seg_t SEG_DASH = 7'b0111111;
  localparam seg_t SEG_OFF  = 7'b1111111;

  localparam an_t AN_OFF = 4'b1111;

  // Digit slot order on the anodes
  localparam logic [1:0] IDX_MIN_LSB = 2'd0;
  localparam logic [1:0] IDX_MIN_MSB = 2'd1;
  localparam logic [1:0] IDX_HR_LSB  = 2'd2;
  localparam logic [1:0] IDX_HR_MSB  = 2'd3;

  typedef struct packed {
    bcd_t hr_msb;
    bcd_t hr_lsb;
    bcd_t min_msb;
    bcd_t min_lsb;
  } digits_t;

  // Active-low one-hot anode for a digit slot
  function automatic an_t an_onehot_n(input logic [1:0] idx);
    return ~(AN_W'(1) << idx);
  endfunction

endpackage

// File: rtl/seven_seg_scan_if.sv
// Digit inputs and display outputs of the seven-segment scanner.
interface seven_seg_scan_if;
  import seg7_pkg::*;

  bcd_t min_LSB;
  bcd_t min_MSB;
  bcd_t hr_LSB;
  bcd_t hr_MSB;
  logic alarm;
  logic blank_lead;
  seg_t seg;
  an_t  an;
  logic dp;

  modport master (
    output min_LSB, min_MSB, hr_LSB, hr_MSB, alarm, blank_lead,
    input  seg, an, dp
  );

  modport slave (
    input  min_LSB, min_MSB, hr_LSB, hr_MSB, alarm, blank_lead,
    output seg, an, dp
  );

endinterface

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to active-low seven-segment decoder; non-decimal codes show a dash.
module bcd_to_seg7
  import seg7_pkg::*;
(
  input  bcd_t bcd,
  output seg_t seg_c
);

  always_comb begin
    seg_c = SEG_DASH;
    case (bcd)
      4'd0:    seg_c = SEG_0;
      4'd1:    seg_c = SEG_1;
      4'd2:    seg_c = SEG_2;
      4'd3:    seg_c = SEG_3;
      4'd4:    seg_c = SEG_4;
      4'd5:    seg_c = SEG_5;
      4'd6:    seg_c = SEG_6;
      4'd7:    seg_c = SEG_7;
      4'd8:    seg_c = SEG_8;
      4'd9:    seg_c = SEG_9;
      default: seg_c = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seven_seg_scan.sv
// Four-digit multiplexed seven-segment scanner with frame-synchronous digit capture,
// anode guard time, leading-zero blanking and alarm blinking.
module seven_seg_scan
  import seg7_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 100_000,
  parameter int unsigned GUARD       = 2,
  parameter int unsigned BLINK_TICKS = 256
) (
  input  logic clk,
  input  logic clr,
  seven_seg_scan_if.slave bus
);

  localparam int unsigned RC_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned BC_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam logic [RC_W-1:0] RC_LAST = RC_W'(REFRESH_DIV - 1);
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(BLINK_TICKS - 1);

  logic [RC_W-1:0] rc;
  logic [1:0]      idx;
  logic [BC_W-1:0] bc;
  logic            bp;
  digits_t         shadow;

  seg_t seg_q;
  an_t  an_q;
  logic dp_q;

  logic slot_wrap_c;
  logic frame_wrap_c;
  logic in_guard_c;
  logic lead_blank_c;
  bcd_t digit_c;
  seg_t seg_code_c;
  an_t  an_c;

  assign slot_wrap_c  = (rc == RC_LAST);
  assign frame_wrap_c = slot_wrap_c && (idx == IDX_HR_MSB);
  assign in_guard_c   = (32'(rc) < GUARD);
  assign lead_blank_c = bus.blank_lead && (idx == IDX_HR_MSB) && (shadow.hr_msb == '0);

  // Digit shown in the current slot always comes from the frame snapshot
  always_comb begin
    digit_c = shadow.min_lsb;
    case (idx)
      IDX_MIN_MSB: digit_c = shadow.min_msb;
      IDX_HR_LSB:  digit_c = shadow.hr_lsb;
      IDX_HR_MSB:  digit_c = shadow.hr_msb;
      default:     digit_c = shadow.min_lsb;
    endcase
  end

  bcd_to_seg7 u_dec (
    .bcd   (digit_c),
    .seg_c (seg_code_c)
  );

  always_comb begin
    an_c = an_onehot_n(idx);
    if (in_guard_c || bp || lead_blank_c) begin
      an_c = AN_OFF;
    end
  end

  // Scan position, snapshot capture and blink phase
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      rc     <= '0;
      idx    <= IDX_MIN_LSB;
      bc     <= '0;
      bp     <= 1'b0;
      shadow <= '0;
    end else begin
      rc <= slot_wrap_c ? '0 : rc + RC_W'(1);
      if (slot_wrap_c) begin
        idx <= idx + 2'd1;
      end
      if (frame_wrap_c) begin
        shadow <= {bus.hr_MSB, bus.hr_LSB, bus.min_MSB, bus.min_LSB};
      end
      // Dropping alarm clears the phase at once so the display reappears
      if (!bus.alarm) begin
        bc <= '0;
        bp <= 1'b0;
      end else if (frame_wrap_c) begin
        if (bc == BC_LAST) begin
          bc <= '0;
          bp <= ~bp;
        end else begin
          bc <= bc + BC_W'(1);
        end
      end
    end
  end

  // Output stage: one cycle behind the scan state
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      seg_q <= SEG_OFF;
      an_q  <= AN_OFF;
      dp_q  <= 1'b1;
    end else begin
      seg_q <= seg_code_c;
      an_q  <= an_c;
      dp_q  <= an_c[IDX_HR_LSB];
    end
  end

  assign bus.seg = seg_q;
  assign bus.an  = an_q;
  assign bus.dp  = dp_q;

endmodule

// File: tb/tb_seven_seg_scan.sv
// Self-checking bench for seven_seg_scan: directed scenarios plus random stimulus
// against a cycle-count based reference model.
module tb_seven_seg_scan;

  localparam int unsigned DIV   = 4;
  localparam int unsigned GRD   = 1;
  localparam int unsigned BLINK = 2;
  localparam int unsigned FRAME = 4 * DIV;

  logic clk = 1'b0;
  logic clr;

  always #5 clk = ~clk;

  seven_seg_scan_if bus ();

  seven_seg_scan #(
    .REFRESH_DIV (DIV),
    .GUARD       (GRD),
    .BLINK_TICKS (BLINK)
  ) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  int errors;
  int checks;

  // Reference state: cycles since reset release, frame snapshot, alarm frames
  int unsigned s;
  logic [3:0]  sh [4];
  int unsigned afr;
  logic [6:0]  e_seg;
  logic [3:0]  e_an;
  logic        e_dp;
  logic [6:0]  seg_ref [16];
  logic [3:0]  an_exp [4];
  logic [6:0]  seg_exp [4];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%0b exp=%0b", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    s     = 0;
    afr   = 0;
    for (int i = 0; i < 4; i++) sh[i] = 4'd0;
    e_seg = 7'b1111111;
    e_an  = 4'b1111;
    e_dp  = 1'b1;
  endtask

  // Outputs after an edge are derived from the state held just before it
  task automatic model_edge();
    int unsigned rc_m;
    int unsigned idx_m;
    logic        dark;
    logic [3:0]  one;
    rc_m  = s % DIV;
    idx_m = (s / DIV) % 4;
    one   = 4'b0001;
    e_seg = seg_ref[sh[idx_m]];
    dark  = (rc_m < GRD) || (((afr / BLINK) % 2) == 1) ||
            (idx_m == 3 && bus.blank_lead && sh[3] == 4'd0);
    e_an  = dark ? 4'b1111 : ~(one << idx_m);
    e_dp  = e_an[2];
    if (!bus.alarm) afr = 0;
    else if ((s % FRAME) == FRAME - 1) afr++;
    if ((s % FRAME) == FRAME - 1) begin
      sh[0] = bus.min_LSB;
      sh[1] = bus.min_MSB;
      sh[2] = bus.hr_LSB;
      sh[3] = bus.hr_MSB;
    end
    s++;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("an", 32'(bus.an), 32'(e_an));
    check("seg", 32'(bus.seg), 32'(e_seg));
    check("dp", 32'(bus.dp), 32'(e_dp));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    seg_ref = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                7'b0000000, 7'b0010000, 7'b0111111, 7'b0111111,
                7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111};
    an_exp  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    seg_exp = '{7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001};
    errors = 0;
    checks = 0;

    clr            = 1'b1;
    bus.min_LSB    = 4'd1;
    bus.min_MSB    = 4'd2;
    bus.hr_LSB     = 4'd3;
    bus.hr_MSB     = 4'd4;
    bus.alarm      = 1'b0;
    bus.blank_lead = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check("rst_an", 32'(bus.an), 32'(4'b1111));
    check("rst_seg", 32'(bus.seg), 32'(7'b1111111));
    check("rst_dp", 32'(bus.dp), 32'(1'b1));
    clr = 1'b0;

    // Basic scan: first frame shows zeros, second frame shows 1,2,3,4
    run(16);
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < DIV; j++) begin
        step();
        check("scan_an", 32'(bus.an), 32'((j < GRD) ? 4'b1111 : an_exp[k]));
        check("scan_seg", 32'(bus.seg), 32'(seg_exp[k]));
        check("scan_dp", 32'(bus.dp), 32'((k == 2 && j >= GRD) ? 1'b0 : 1'b1));
      end
    end

    // Mid-frame change is held off until the frame boundary
    bus.min_LSB = 4'd5;
    run(16);
    for (int j = 0; j < DIV; j++) begin
      step();
      check("hold5_seg", 32'(bus.seg), 32'(7'b0010010));
    end
    step();
    bus.min_LSB = 4'd7;
    run(11);
    for (int j = 0; j < DIV; j++) begin
      step();
      check("new7_seg", 32'(bus.seg), 32'(7'b1111000));
    end

    // Non-decimal code shows a dash
    bus.hr_LSB = 4'hC;
    run(12);
    run(8);
    for (int j = 0; j < DIV; j++) begin
      step();
      check("dash_seg", 32'(bus.seg), 32'(7'b0111111));
    end

    // Leading-zero blanking, then a non-zero hours-tens digit
    bus.hr_MSB     = 4'd0;
    bus.blank_lead = 1'b1;
    run(4);
    run(12);
    for (int j = 0; j < DIV; j++) begin
      step();
      check("blank_an", 32'(bus.an), 32'(4'b1111));
    end
    bus.hr_MSB = 4'd1;
    run(16);
    run(12);
    for (int j = 0; j < DIV; j++) begin
      step();
      check("lead1_an", 32'(bus.an), 32'((j < GRD) ? 4'b1111 : 4'b0111));
    end

    // Alarm blink: 8 visible slots, 8 dark slots, repeating
    bus.alarm = 1'b1;
    for (int slot = 0; slot < 32; slot++) begin
      for (int j = 0; j < DIV; j++) begin
        step();
        if (j == DIV - 1)
          check("blink_vis", 32'(bus.an != 4'b1111), 32'(((slot / 8) % 2) == 0));
      end
    end
    run(34);
    bus.alarm = 1'b0;
    step();
    step();
    check("alarm_drop_an", 32'(bus.an), 32'(4'b1110));

    // Asynchronous clear between edges in slot 2
    run(6);
    #2 clr = 1'b1;
    #1;
    check("clr_an", 32'(bus.an), 32'(4'b1111));
    check("clr_seg", 32'(bus.seg), 32'(7'b1111111));
    check("clr_dp", 32'(bus.dp), 32'(1'b1));
    @(negedge clk);
    clr = 1'b0;
    model_reset();
    step();
    check("post_guard_an", 32'(bus.an), 32'(4'b1111));
    check("post_guard_seg", 32'(bus.seg), 32'(7'b1000000));
    step();
    check("post_slot0_an", 32'(bus.an), 32'(4'b1110));
    check("post_slot0_seg", 32'(bus.seg), 32'(7'b1000000));

    // Random traffic against the model
    bus.blank_lead = 1'b0;
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 7) == 0) bus.min_LSB = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) bus.min_MSB = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) bus.hr_LSB  = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) bus.hr_MSB  = 4'($urandom_range(0, 3));
      if ($urandom_range(0, 39) == 0) bus.alarm = ~bus.alarm;
      if ($urandom_range(0, 29) == 0) bus.blank_lead = ~bus.blank_lead;
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
